// File: rtl/rackctl_wb_target.sv
// RACKctl SURF-side responder: turns one PHY transaction (parallel strobe or
// 32-bit command stream) into a single WISHBONE master cycle and reports done/err.
module rackctl_wb_target #(
  parameter int TIMEOUT   = 255,
  parameter int ADDR_BITS = 22
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 mode_i,
  input  logic [23:0]          txn_addr_i,
  input  logic [31:0]          txn_data_i,
  input  logic                 txn_start_i,
  input  logic [31:0]          s_cmd_tdata,
  input  logic                 s_cmd_tvalid,
  output logic                 s_cmd_tready,
  input  logic                 s_cmd_tlast,
  output logic [31:0]          txn_resp_o,
  output logic                 txn_done_o,
  output logic                 txn_err_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [ADDR_BITS-1:0] wb_adr_o,
  output logic [31:0]          wb_dat_o,
  output logic [3:0]           wb_sel_o,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  input  logic                 wb_rty_i,
  output logic                 bridge_err_o,
  input  logic                 err_rst_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD_DATA = 2'd1,
    CYCLE    = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [31:0] RESP_ERR = 32'hFFFF_FFFF;

  state_t                 r_state, w_state_nxt;
  logic                   r_mode, w_mode_nxt;
  logic                   r_cyc, w_cyc_nxt;
  logic                   r_we, w_we_nxt;
  logic [ADDR_BITS-1:0]   r_adr, w_adr_nxt;
  logic [31:0]            r_dat, w_dat_nxt;
  logic [15:0]            r_tmo_cnt, w_tmo_cnt_nxt;
  logic [31:0]            r_resp, w_resp_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_err, w_err_nxt;
  logic                   r_bridge_err;
  logic                   w_bridge_set;
  logic                   w_tready;
  logic                   w_term;
  logic                   w_unused;

  // Reserved address bit and the command word's upper byte carry no meaning here.
  assign w_unused = ^{txn_addr_i[22], s_cmd_tdata[31:24], s_cmd_tdata[22]};

  assign w_term = wb_ack_i | wb_err_i | wb_rty_i;

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_cyc_nxt     = r_cyc;
    w_we_nxt      = r_we;
    w_adr_nxt     = r_adr;
    w_dat_nxt     = r_dat;
    w_tmo_cnt_nxt = r_tmo_cnt;
    w_resp_nxt    = r_resp;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_bridge_set  = 1'b0;
    w_tready      = 1'b0;

    case (r_state)
      IDLE: begin
        w_mode_nxt = mode_i;
        w_tready   = r_mode;
        if (!r_mode && txn_start_i) begin
          w_adr_nxt     = txn_addr_i[ADDR_BITS-1:0];
          w_we_nxt      = ~txn_addr_i[23];
          w_dat_nxt     = txn_data_i;
          w_cyc_nxt     = 1'b1;
          w_tmo_cnt_nxt = '0;
          w_state_nxt   = CYCLE;
        end else if (r_mode && s_cmd_tvalid) begin
          w_adr_nxt = s_cmd_tdata[ADDR_BITS-1:0];
          w_we_nxt  = ~s_cmd_tdata[23];
          if (s_cmd_tdata[23]) begin
            w_cyc_nxt     = 1'b1;
            w_tmo_cnt_nxt = '0;
            w_state_nxt   = CYCLE;
          end else if (!s_cmd_tlast) begin
            w_state_nxt = CMD_DATA;
          end else begin
            // A write command with no data word is a framing error.
            w_resp_nxt   = RESP_ERR;
            w_err_nxt    = 1'b1;
            w_bridge_set = 1'b1;
            w_state_nxt  = RESP;
          end
        end
      end

      CMD_DATA: begin
        w_tready = 1'b1;
        if (s_cmd_tvalid) begin
          w_dat_nxt     = s_cmd_tdata;
          w_cyc_nxt     = 1'b1;
          w_tmo_cnt_nxt = '0;
          w_state_nxt   = CYCLE;
        end
      end

      CYCLE: begin
        if (w_term) begin
          w_cyc_nxt   = 1'b0;
          w_state_nxt = RESP;
          if (wb_err_i || wb_rty_i) begin
            w_resp_nxt   = RESP_ERR;
            w_err_nxt    = 1'b1;
            w_bridge_set = 1'b1;
          end else begin
            w_resp_nxt = r_we ? r_dat : wb_dat_i;
            w_done_nxt = 1'b1;
          end
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_cyc_nxt    = 1'b0;
          w_resp_nxt   = RESP_ERR;
          w_err_nxt    = 1'b1;
          w_bridge_set = 1'b1;
          w_state_nxt  = RESP;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
        end
      end

      RESP: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // A parallel-mode strobe outside IDLE has nowhere to go.
    if (r_state != IDLE && !r_mode && txn_start_i) begin
      w_bridge_set = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= IDLE;
      r_mode       <= 1'b0;
      r_cyc        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_dat        <= '0;
      r_tmo_cnt    <= '0;
      r_resp       <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_bridge_err <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mode       <= w_mode_nxt;
      r_cyc        <= w_cyc_nxt;
      r_we         <= w_we_nxt;
      r_adr        <= w_adr_nxt;
      r_dat        <= w_dat_nxt;
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      r_resp       <= w_resp_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      // Set beats clear when both land on the same edge.
      r_bridge_err <= w_bridge_set | (r_bridge_err & ~err_rst_i);
    end
  end

  assign s_cmd_tready = w_tready;
  assign txn_resp_o   = r_resp;
  assign txn_done_o   = r_done;
  assign txn_err_o    = r_err;
  assign wb_cyc_o     = r_cyc;
  assign wb_stb_o     = r_cyc;
  assign wb_we_o      = r_we;
  assign wb_adr_o     = r_adr;
  assign wb_dat_o     = r_dat;
  assign wb_sel_o     = 4'hF;
  assign bridge_err_o = r_bridge_err;

endmodule
